// File: rtl/id_of_stage.sv
// -----------------------------------------------------------------------------
// id_of_stage
//   Instruction-decode / operand-fetch stage. Decodes IR, reads the register
//   file and registers the execute-stage bundle. A RAW hazard against the
//   instruction now in execute makes this stage insert a bubble and raise
//   stall so fetch holds IR/PC_in. A flush kills the instruction in decode.
//
//   Optional macro REGFILE_BYPASS_EN:
//     defined   - a same-cycle write-back to SA/SB is forwarded into A/B.
//     undefined - a same-cycle write-back to a used source stalls one cycle
//                 so the instruction re-reads the updated register.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   IR, PC_in               instruction and its PC from fetch
//   flush                   kill the instruction being decoded
//   wb_we, wb_addr, wb_data register-file write-back port
//   A, B, PC                registered operands and PC
//   RW, MW, DA, FS, SH,     registered control bundle for execute
//   BS, PS, MD
//   stall                   combinational fetch hold request
//   illegal                 registered undefined-opcode flag
// -----------------------------------------------------------------------------
module id_of_stage #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     IR,
    input  logic [XLEN-1:0] PC_in,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [XLEN-1:0] PC,
    output logic            RW,
    output logic            MW,
    output logic [4:0]      DA,
    output logic [4:0]      FS,
    output logic [4:0]      SH,
    output logic [1:0]      BS,
    output logic            PS,
    output logic [1:0]      MD,
    output logic            stall,
    output logic            illegal
);

    localparam logic [6:0] OP_NOP = 7'h00;
    localparam logic [6:0] OP_ADD = 7'h02;
    localparam logic [6:0] OP_SUB = 7'h05;
    localparam logic [6:0] OP_AND = 7'h08;
    localparam logic [6:0] OP_LSL = 7'h0D;
    localparam logic [6:0] OP_ADI = 7'h22;
    localparam logic [6:0] OP_LD  = 7'h21;
    localparam logic [6:0] OP_ST  = 7'h01;
    localparam logic [6:0] OP_BZ  = 7'h20;
    localparam logic [6:0] OP_BNZ = 7'h60;
    localparam logic [6:0] OP_JMP = 7'h44;

    typedef enum logic [1:0] {B_ZERO, B_REG, B_ZEXT, B_SEXT} b_src_t;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  dr, sa, sb;
    logic [14:0] imm;
    assign opcode = IR[31:25];
    assign dr     = IR[24:20];
    assign sa     = IR[19:15];
    assign sb     = IR[14:10];
    assign imm    = IR[14:0];

    // ------------------------------------------------------------------
    // Register file: one register per entry so reset can clear it; entry 0
    // is held at zero so reads of R0 need no special case.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [4:0] IDX = 5'(gi);
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk) begin
                    regs[gi] <= '0;
                end
            end else begin : g_rw
                always_ff @(posedge clk) begin
                    if (reset) begin
                        regs[gi] <= '0;
                    end else if (wb_we && (wb_addr == IDX)) begin
                        regs[gi] <= wb_data;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       dec_rw, dec_mw, dec_ps, dec_illegal, sa_used, sb_used;
    logic [4:0] dec_fs;
    logic [1:0] dec_bs, dec_md;
    b_src_t     dec_bsrc;

    always_comb begin
        dec_rw      = 1'b0;
        dec_mw      = 1'b0;
        dec_fs      = 5'd0;
        dec_bs      = 2'b00;
        dec_ps      = 1'b0;
        dec_md      = 2'b00;
        dec_bsrc    = B_ZERO;
        dec_illegal = 1'b0;
        sa_used     = 1'b1;
        sb_used     = 1'b0;
        case (opcode)
            OP_NOP: sa_used = 1'b0;
            OP_ADD: begin dec_rw = 1'b1; dec_fs = 5'b00010; dec_bsrc = B_REG; sb_used = 1'b1; end
            OP_SUB: begin dec_rw = 1'b1; dec_fs = 5'b00101; dec_bsrc = B_REG; sb_used = 1'b1; end
            OP_AND: begin dec_rw = 1'b1; dec_fs = 5'b01000; dec_bsrc = B_REG; sb_used = 1'b1; end
            OP_LSL: begin dec_rw = 1'b1; dec_fs = 5'b01101; end
            OP_ADI: begin dec_rw = 1'b1; dec_fs = 5'b00010; dec_bsrc = B_ZEXT; end
            OP_LD:  begin dec_rw = 1'b1; dec_md = 2'b01; end
            OP_ST:  begin dec_mw = 1'b1; dec_bsrc = B_REG; sb_used = 1'b1; end
            OP_BZ:  begin dec_bs = 2'b01; dec_bsrc = B_SEXT; end
            OP_BNZ: begin dec_bs = 2'b01; dec_ps = 1'b1; dec_bsrc = B_SEXT; end
            OP_JMP: begin dec_bs = 2'b10; dec_bsrc = B_SEXT; sa_used = 1'b0; end
            default: begin
                // Undefined opcodes become a bubble and read nothing.
                dec_illegal = 1'b1;
                sa_used     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand read and write-back interaction
    // ------------------------------------------------------------------
    logic [XLEN-1:0] op_a, op_b;
    logic            wb_stall;

`ifdef REGFILE_BYPASS_EN
    // Write-before-read: the value being written this cycle wins.
    always_comb begin
        op_a     = regs[sa];
        op_b     = regs[sb];
        wb_stall = 1'b0;
        if (wb_we && (wb_addr != 5'd0) && (wb_addr == sa)) op_a = wb_data;
        if (wb_we && (wb_addr != 5'd0) && (wb_addr == sb)) op_b = wb_data;
    end
`else
    // The array returns the pre-write value, so retry after the write lands.
    always_comb begin
        op_a     = regs[sa];
        op_b     = regs[sb];
        wb_stall = wb_we && (wb_addr != 5'd0) &&
                   ((sa_used && (wb_addr == sa)) || (sb_used && (wb_addr == sb)));
    end
`endif

    // ------------------------------------------------------------------
    // Hazard detection against the instruction now in execute
    // ------------------------------------------------------------------
    logic            rw_reg, mw_reg, ps_reg, illegal_reg;
    logic [4:0]      da_reg, fs_reg, sh_reg;
    logic [1:0]      bs_reg, md_reg;
    logic [XLEN-1:0] a_reg, b_reg, pc_reg;
    logic            raw_stall;

    assign raw_stall = rw_reg && (da_reg != 5'd0) &&
                       ((sa_used && (da_reg == sa)) || (sb_used && (da_reg == sb)));
    assign stall     = !reset && !flush && (raw_stall || wb_stall);

    // ------------------------------------------------------------------
    // Next output bundle
    // ------------------------------------------------------------------
    logic            rw_next, mw_next, ps_next, illegal_next;
    logic [4:0]      da_next, fs_next, sh_next;
    logic [1:0]      bs_next, md_next;
    logic [XLEN-1:0] a_next, b_next, pc_next;

    always_comb begin
        rw_next      = 1'b0;
        mw_next      = 1'b0;
        ps_next      = 1'b0;
        illegal_next = 1'b0;
        da_next      = 5'd0;
        fs_next      = 5'd0;
        sh_next      = 5'd0;
        bs_next      = 2'b00;
        md_next      = 2'b00;
        a_next       = '0;
        b_next       = '0;
        pc_next      = '0;
        if (flush || stall) begin
            // bubble
        end else if (dec_illegal) begin
            illegal_next = 1'b1;
        end else begin
            rw_next = dec_rw;
            mw_next = dec_mw;
            ps_next = dec_ps;
            da_next = dec_rw ? dr : 5'd0;
            fs_next = dec_fs;
            sh_next = imm[4:0];
            bs_next = dec_bs;
            md_next = dec_md;
            a_next  = op_a;
            pc_next = PC_in;
            case (dec_bsrc)
                B_REG:   b_next = op_b;
                B_ZEXT:  b_next = {{(XLEN-15){1'b0}}, imm};
                B_SEXT:  b_next = {{(XLEN-15){imm[14]}}, imm};
                default: b_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_reg      <= 1'b0;
            mw_reg      <= 1'b0;
            ps_reg      <= 1'b0;
            illegal_reg <= 1'b0;
            da_reg      <= 5'd0;
            fs_reg      <= 5'd0;
            sh_reg      <= 5'd0;
            bs_reg      <= 2'b00;
            md_reg      <= 2'b00;
            a_reg       <= '0;
            b_reg       <= '0;
            pc_reg      <= '0;
        end else begin
            rw_reg      <= rw_next;
            mw_reg      <= mw_next;
            ps_reg      <= ps_next;
            illegal_reg <= illegal_next;
            da_reg      <= da_next;
            fs_reg      <= fs_next;
            sh_reg      <= sh_next;
            bs_reg      <= bs_next;
            md_reg      <= md_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            pc_reg      <= pc_next;
        end
    end

    assign A       = a_reg;
    assign B       = b_reg;
    assign PC      = pc_reg;
    assign RW      = rw_reg;
    assign MW      = mw_reg;
    assign DA      = da_reg;
    assign FS      = fs_reg;
    assign SH      = sh_reg;
    assign BS      = bs_reg;
    assign PS      = ps_reg;
    assign MD      = md_reg;
    assign illegal = illegal_reg;

endmodule

// File: doc/id_of_stage.md
Name: id_of_stage

Overview:
- Instruction-decode / operand-fetch stage; the producer side of the execute-stage input bundle (A, B, PC, RW, MW, DA, FS, SH, BS, PS, MD).
- Decodes a 32-bit instruction and reads a 32x32 register file. The register file is written back by the write-back path.
- Detects RAW hazards against the instruction currently in execute; inserts a bubble and stalls fetch when one is found.
- Accepts a flush from the branch logic (pcsrc != 0) and kills the instruction it is decoding.

Parameters:
- NREG, 32, number of architectural registers; R0 reads as 0 and writes to it are ignored.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- IR  in  32  instruction from fetch: opcode=IR[31:25], DR=IR[24:20], SA=IR[19:15], SB=IR[14:10], IMM=IR[14:0].
- PC_in  in  32  PC of IR.
- flush  in  1  kill current decode (taken branch or jump).
- wb_we  in  1  register-file write enable.
- wb_addr  in  5  write address.
- wb_data  in  32  write data.
- A, B  out  32  operands to execute.
- PC  out  32  registered PC_in.
- RW, MW  out  1  register-write and memory-write controls.
- DA  out  5  destination register.
- FS  out  5  ALU function select.
- SH  out  5  shift amount.
- BS  out  2  branch select.
- PS  out  1  branch polarity.
- MD  out  2  write-back mux select.
- stall  out  1  combinational; fetch holds PC and IR while high.
- illegal  out  1  registered; high for one stage slot when the decoded opcode is undefined.

Behaviour:
- All outputs are registered on posedge clk. Latency is 1 cycle from IR to outputs.
- Reset: every registered output is 0, which equals a bubble. Register-file contents are cleared to 0.
- Bubble: RW=0, MW=0, BS=00, PS=0, MD=00, DA=0, FS=0, SH=0, A=0, B=0, PC=0, illegal=0.
- Decode table (opcode hex: RW MW FS BS PS MD, B source):
  - 00 NOP: 0 0 00000 00 0 00, B=0
  - 02 ADD: 1 0 00010 00 0 00, B=R[SB]
  - 05 SUB: 1 0 00101 00 0 00, B=R[SB]
  - 08 AND: 1 0 01000 00 0 00, B=R[SB]
  - 0D LSL: 1 0 01101 00 0 00, B=0, SH=IMM[4:0]
  - 22 ADI: 1 0 00010 00 0 00, B=zero-extended IMM
  - 21 LD: 1 0 00000 00 0 01, B=0
  - 01 ST: 0 1 00000 00 0 00, B=R[SB]
  - 20 BZ: 0 0 00000 01 0 00, B=sign-extended IMM
  - 60 BNZ: 0 0 00000 01 1 00, B=sign-extended IMM
  - 44 JMP: 0 0 00000 10 0 00, B=sign-extended IMM
  - For every opcode: A=R[SA]; DA=DR when RW=1, else 0.
  - SH=IMM[4:0] for all opcodes except a bubble.
  - Any other opcode is decoded as a bubble with illegal=1.
- Register file:
  - R0 is hardwired to 0.
  - A write with wb_we=1 and wb_addr!=0 takes effect at posedge.
- Source usage:
  - SA is used by every opcode except NOP and JMP.
  - SB is used by ADD, SUB, AND and ST.
- Hazard: stall=1 when all of the following hold:
  - the registered RW=1 and DA!=0;
  - DA equals a used source of IR;
  - flush=0.
  - On stall, the output register loads a bubble and IR/PC_in are held by fetch. Stall therefore lasts exactly 1 cycle per hazard.
- Flush has priority: flush=1 loads a bubble, forces stall=0, and sets illegal=0.
- reset has priority over flush.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wb_we=1 and wb_addr matches SA or SB (non-zero) in the same cycle, wb_data is forwarded into A or B (write-before-read).
- Undefined: the register file returns the old value. Stall is additionally asserted when wb_we=1, wb_addr!=0 and wb_addr equals a used source, so the instruction retries next cycle.

Test Plan:
1. Reset: assert reset with IR=ADD -> all outputs 0 next cycle; stall=0.
2. ADI then ADD:
   - Stimulus: R3=5; IR=ADI DR=4 SA=3 IMM=0x0007, followed by ADD DR=5 SA=4 SB=3.
   - Required: ADI outputs A=5, B=7, FS=00010, RW=1, DA=4. ADD then raises stall=1 for one cycle, producing one bubble, and issues after the stall.
3. BNZ sign extension: IR=BNZ IMM=0x7FFC (negative) -> B=0xFFFFFFFC, BS=01, PS=1, RW=0, DA=0.
4. Flush during stall: hazard present and flush=1 in the same cycle -> stall=0; outputs are a bubble.
5. Illegal and R0:
   - IR opcode 7F -> bubble with illegal=1 for exactly 1 cycle.
   - wb_we=1, wb_addr=0, wb_data=0xDEADBEEF, then read R0 -> A=0.
6. Same-cycle write-back: wb_we=1, wb_addr=3, wb_data=0x1234 while IR=ADD SA=3 SB=0.
   - With REGFILE_BYPASS_EN: A=0x1234 next cycle, no stall.
   - Without: stall=1 for one cycle, then A=0x1234.
